// File: rtl/sprite_pkg.sv
// Shared sizes, command payload and FSM state encoding for the sprite blitter.
package sprite_pkg;

  localparam int unsigned WIDTH         = 640;
  localparam int unsigned HEIGHT        = 480;
  localparam int unsigned S_WIDTH       = 48;
  localparam int unsigned S_HEIGHT      = 48;
  localparam int unsigned SPRITE_PIXELS = S_WIDTH * S_HEIGHT;
  localparam logic [7:0]  TRANSPARENT   = 8'hE3;

  localparam int unsigned ID_W   = 2;
  localparam int unsigned X_W    = 10;
  localparam int unsigned Y_W    = 9;
  localparam int unsigned ROM_AW = 14;
  localparam int unsigned FB_AW  = 19;
  localparam int unsigned PIX_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [X_W-1:0]  x;
    logic [Y_W-1:0]  y;
  } blit_cmd_t;

endpackage

// File: rtl/blit_addr_gen.sv
// Raster-order sprite pixel counters (i fastest) with a last-pixel flag.
module blit_addr_gen
  import sprite_pkg::*;
#(
  parameter int unsigned CNT_W = S_WIDTH,
  parameter int unsigned CNT_H = S_HEIGHT,
  parameter int unsigned IW    = $clog2(CNT_W),
  parameter int unsigned JW    = $clog2(CNT_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          step,
  output logic [IW-1:0] i,
  output logic [JW-1:0] j,
  output logic          last_c
);

  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic          i_wrap;
  logic          j_wrap;

  assign i_wrap = (i_q == IW'(CNT_W - 1));
  assign j_wrap = (j_q == JW'(CNT_H - 1));
  assign last_c = i_wrap && j_wrap;
  assign i      = i_q;
  assign j      = j_q;

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    if (start) begin
      i_d = '0;
      j_d = '0;
    end else if (step) begin
      if (i_wrap) begin
        i_d = '0;
        j_d = j_wrap ? '0 : j_q + JW'(1);
      end else begin
        i_d = i_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q <= '0;
      j_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

endmodule

// File: rtl/sprite_blit_ctrl.sv
// Copies one 48x48 ROM sprite into the framebuffer at (x,y), clipping at the
// screen edges and skipping the transparent colour.
module sprite_blit_ctrl #(
  parameter int unsigned WIDTH       = sprite_pkg::WIDTH,
  parameter int unsigned HEIGHT      = sprite_pkg::HEIGHT,
  parameter int unsigned S_WIDTH     = sprite_pkg::S_WIDTH,
  parameter int unsigned S_HEIGHT    = sprite_pkg::S_HEIGHT,
  parameter logic [7:0]  TRANSPARENT = sprite_pkg::TRANSPARENT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_id,
  input  logic [9:0]  cmd_x,
  input  logic [8:0]  cmd_y,
  output logic [13:0] rom_addr,
  input  logic [7:0]  rom_dout,
  output logic        we,
  output logic [18:0] addr,
  output logic [7:0]  dout,
  output logic        busy,
  output logic        done
);

  import sprite_pkg::state_e;
  import sprite_pkg::blit_cmd_t;
  import sprite_pkg::ST_IDLE;
  import sprite_pkg::ST_RUN;
  import sprite_pkg::ST_DRAIN;
  import sprite_pkg::X_W;
  import sprite_pkg::Y_W;
  import sprite_pkg::ROM_AW;
  import sprite_pkg::FB_AW;

  localparam int unsigned PIX   = S_WIDTH * S_HEIGHT;
  localparam int unsigned IW    = $clog2(S_WIDTH);
  localparam int unsigned JW    = $clog2(S_HEIGHT);
  localparam int unsigned PX_W  = X_W + 1;
  localparam int unsigned PY_W  = Y_W + 1;
  localparam int unsigned TGT_W = PY_W + $clog2(WIDTH) + 1;

  state_e                state_q, state_d;
  blit_cmd_t             cmd_q, cmd_d;
  logic [ROM_AW-1:0]     rom_addr_q, rom_addr_d;
  logic                  valid_q, valid_d;
  logic                  inb_q, inb_d;
  logic [FB_AW-1:0]      addr_q, addr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ready_q, ready_d;

  logic                  start;
  logic                  step;
  logic                  last_c;
  logic [IW-1:0]         i;
  logic [JW-1:0]         j;
  logic [PX_W-1:0]       px_c;
  logic [PY_W-1:0]       py_c;
  logic [TGT_W-1:0]      tgt_c;

  blit_addr_gen #(
    .CNT_W (S_WIDTH),
    .CNT_H (S_HEIGHT),
    .IW    (IW),
    .JW    (JW)
  ) u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .step   (step),
    .i      (i),
    .j      (j),
    .last_c (last_c)
  );

  // Framebuffer coordinate of the pixel being issued, kept wide so that
  // off-screen pixels are clipped rather than wrapped.
  assign px_c  = PX_W'(cmd_q.x) + PX_W'(i);
  assign py_c  = PY_W'(cmd_q.y) + PY_W'(j);
  assign tgt_c = TGT_W'(py_c) * TGT_W'(WIDTH) + TGT_W'(px_c);

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    rom_addr_d = rom_addr_q;
    start      = 1'b0;
    step       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d    = ST_RUN;
          cmd_d      = '{id: cmd_id, x: cmd_x, y: cmd_y};
          start      = 1'b1;
          rom_addr_d = ROM_AW'(cmd_id) * ROM_AW'(PIX);
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (last_c) begin
          state_d = ST_DRAIN;
        end else begin
          rom_addr_d = rom_addr_q + ROM_AW'(1);
        end
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Target stage runs alongside the ROM read latency.
    valid_d = (state_q == ST_RUN);
    inb_d   = (32'(px_c) < WIDTH) && (32'(py_c) < HEIGHT);
    addr_d  = (valid_d && inb_d) ? FB_AW'(tgt_c) : addr_q;

    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DRAIN);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      rom_addr_q <= '0;
      valid_q    <= 1'b0;
      inb_q      <= 1'b0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      rom_addr_q <= rom_addr_d;
      valid_q    <= valid_d;
      inb_q      <= inb_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  // Write strobe must follow the ROM data, which arrives in this cycle.
  assign we        = valid_q && inb_q && (rom_dout != TRANSPARENT);
  assign dout      = rom_dout;
  assign addr      = addr_q;
  assign rom_addr  = rom_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_ready = ready_q;

endmodule
